// File: rtl/board_mem_arbiter.sv
// Shares the single board BRAM port between the renderer, the generation updater and the
// cursor editor. The renderer always wins while drawing; during blanking a pending edit beats the updater.
module board_mem_arbiter #(
    parameter int LOG_MAX_ADDR = 12,
    parameter int WORD_SIZE    = 16,
    parameter int RD_LATENCY   = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    render_done_in,
    input  logic [LOG_MAX_ADDR-1:0] render_addr_in,
    output logic [WORD_SIZE-1:0]    render_data_out,
    input  logic                    upd_req_in,
    input  logic                    upd_we_in,
    input  logic [LOG_MAX_ADDR-1:0] upd_addr_in,
    input  logic [WORD_SIZE-1:0]    upd_data_in,
    output logic                    upd_gnt_out,
    output logic                    upd_rvalid_out,
    output logic [WORD_SIZE-1:0]    upd_data_out,
    input  logic                    edit_req_in,
    input  logic [LOG_MAX_ADDR-1:0] edit_addr_in,
    input  logic [WORD_SIZE-1:0]    edit_mask_in,
    output logic                    edit_busy_out,
    output logic [LOG_MAX_ADDR-1:0] mem_addr_out,
    output logic                    mem_we_out,
    output logic [WORD_SIZE-1:0]    mem_din_out,
    input  logic [WORD_SIZE-1:0]    mem_dout_in,
    output logic [2:0]              state_out
);

    localparam logic [2:0] ST_RENDER    = 3'd0;
    localparam logic [2:0] ST_UPD       = 3'd1;
    localparam logic [2:0] ST_EDIT_RD   = 3'd2;
    localparam logic [2:0] ST_EDIT_WAIT = 3'd3;
    localparam logic [2:0] ST_EDIT_WR   = 3'd4;
    localparam int         CNT_W        = 4;

    logic [2:0]              state_q, state_d;
    logic                    busy_q, busy_d;
    logic [LOG_MAX_ADDR-1:0] eaddr_q, eaddr_d;
    logic [WORD_SIZE-1:0]    emask_q, emask_d;
    logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
    logic [RD_LATENCY-1:0]   tag_q, tag_d;
    logic                    edit_accept_s;
    logic                    edit_wr_s;
    logic                    upd_rd_gnt_s;

    assign edit_accept_s   = edit_req_in & ~busy_q;
    assign upd_rd_gnt_s    = upd_gnt_out & ~upd_we_in;
    assign render_data_out = mem_dout_in;
    assign upd_rvalid_out  = tag_q[RD_LATENCY-1];
    assign upd_data_out    = upd_rvalid_out ? mem_dout_in : {WORD_SIZE{1'b0}};
    assign edit_busy_out   = busy_q;
    assign state_out       = state_q;

    // Edit capture: requests arriving while an edit is outstanding are dropped, not queued.
    always_comb begin
        busy_d  = busy_q;
        eaddr_d = eaddr_q;
        emask_d = emask_q;
        if (edit_accept_s) begin
            busy_d  = 1'b1;
            eaddr_d = edit_addr_in;
            emask_d = edit_mask_in;
        end else if (edit_wr_s) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end
    end

    // Port ownership and next state; a drawing renderer overrides everything in the same cycle.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mem_addr_out = render_addr_in;
        mem_we_out   = 1'b0;
        mem_din_out  = upd_data_in;
        upd_gnt_out  = 1'b0;
        edit_wr_s    = 1'b0;
        if (!render_done_in) begin
            state_d = ST_RENDER;
        end else begin
            case (state_q)
                ST_RENDER: begin
                    state_d = busy_q ? ST_EDIT_RD : ST_UPD;
                end
                ST_UPD: begin
                    mem_addr_out = upd_addr_in;
                    if (busy_q) begin
                        state_d = ST_EDIT_RD;
                    end else begin
                        // An edit accepted now still lets this cycle's updater access through.
                        upd_gnt_out = upd_req_in;
                        mem_we_out  = upd_req_in & upd_we_in;
                        state_d     = edit_req_in ? ST_EDIT_RD : ST_UPD;
                    end
                end
                ST_EDIT_RD: begin
                    mem_addr_out = eaddr_q;
                    wait_cnt_d   = CNT_W'(RD_LATENCY - 2);
                    state_d      = ST_EDIT_WAIT;
                end
                ST_EDIT_WAIT: begin
                    mem_addr_out = eaddr_q;
                    if (wait_cnt_q == {CNT_W{1'b0}}) begin
                        state_d = ST_EDIT_WR;
                    end else begin
                        wait_cnt_d = wait_cnt_q - CNT_W'(1);
                    end
                end
                ST_EDIT_WR: begin
                    mem_addr_out = eaddr_q;
                    mem_we_out   = 1'b1;
                    mem_din_out  = mem_dout_in ^ emask_q;
                    edit_wr_s    = 1'b1;
                    state_d      = ST_UPD;
                end
                default: begin
                    state_d = ST_RENDER;
                end
            endcase
        end
    end

    // Read tags track granted updater reads through the BRAM pipeline, independent of state.
    always_comb begin
        tag_d = {tag_q[RD_LATENCY-2:0], upd_rd_gnt_s};
    end

    // State registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_RENDER;
            busy_q     <= 1'b0;
            eaddr_q    <= {LOG_MAX_ADDR{1'b0}};
            emask_q    <= {WORD_SIZE{1'b0}};
            wait_cnt_q <= {CNT_W{1'b0}};
            tag_q      <= {RD_LATENCY{1'b0}};
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            eaddr_q    <= eaddr_d;
            emask_q    <= emask_d;
            wait_cnt_q <= wait_cnt_d;
            tag_q      <= tag_d;
        end
    end

endmodule

// File: doc/board_mem_arbiter.md
Name: board_mem_arbiter

Overview:
- Owns the single port of the board BRAM and shares it between three requesters: the renderer's per-pixel read stream, the generation updater (read/write), and the cursor editor (toggle a cell).
- The renderer has absolute priority while it is drawing, i.e. while render_done_in is low.
- During blanking (render_done_in high), the editor's read-modify-write takes precedence over the updater.
- Sits between renderer/updater/editor and the board memory in the top level.

Parameters:
- LOG_MAX_ADDR, 12: board memory address width.
- WORD_SIZE, 16: bits per memory word; one bit per cell, MSB = leftmost cell.
- RD_LATENCY, 2: BRAM read latency in cycles, from address to mem_dout_in valid.

Ports:
- clk_in, input, 1: system clock.
- rst_n_in, input, 1: asynchronous active-low reset.
- render_done_in, input, 1: high during renderer blank period; memory may be lent out.
- render_addr_in, input, LOG_MAX_ADDR: renderer read address.
- render_data_out, output, WORD_SIZE: read data to renderer; combinational copy of mem_dout_in.
- upd_req_in, input, 1: updater requests one access this cycle.
- upd_we_in, input, 1: updater write enable.
- upd_addr_in, input, LOG_MAX_ADDR: updater address.
- upd_data_in, input, WORD_SIZE: updater write data.
- upd_gnt_out, output, 1: access accepted this cycle (combinational).
- upd_rvalid_out, output, 1: upd_data_out carries data for a granted read.
- upd_data_out, output, WORD_SIZE: updater read data.
- edit_req_in, input, 1: single-cycle pulse requesting a cell toggle.
- edit_addr_in, input, LOG_MAX_ADDR: word address to toggle in.
- edit_mask_in, input, WORD_SIZE: XOR mask applied to the word.
- edit_busy_out, output, 1: an edit is pending or in progress.
- mem_addr_out, output, LOG_MAX_ADDR: BRAM address.
- mem_we_out, output, 1: BRAM write enable.
- mem_din_out, output, WORD_SIZE: BRAM write data.
- mem_dout_in, input, WORD_SIZE: BRAM read data.
- state_out, output, 3: current FSM state encoding, for debug.

Behaviour:
- Reset (async, rst_n_in low), all values:
  - FSM state = RENDER.
  - edit_busy_out = 0; edit pending latch cleared; captured edit address and mask = 0.
  - upd_rvalid_out = 0; read-tag shift register = 0.
- States:
  - RENDER = 0: mem_addr_out = render_addr_in, mem_we_out = 0, upd_gnt_out = 0.
  - UPD = 1: mem_addr_out, mem_we_out and mem_din_out come from the updater. upd_gnt_out = upd_req_in. mem_we_out = upd_req_in & upd_we_in.
  - EDIT_RD = 2: mem_addr_out = captured edit address, mem_we_out = 0.
  - EDIT_WAIT = 3: holds the edit address for RD_LATENCY-1 cycles using a counter.
  - EDIT_WR = 4: mem_we_out = 1, mem_din_out = mem_dout_in ^ captured mask.
- Edit capture:
  - edit_req_in while edit_busy_out = 0 latches address and mask, and sets busy on the next edge.
  - edit_req_in while busy is ignored; it is not queued.
  - busy clears the cycle after the EDIT_WR write.
- Transitions:
  - RENDER -> EDIT_RD when render_done_in = 1 and an edit is pending.
  - RENDER -> UPD when render_done_in = 1 and no edit is pending.
  - UPD -> EDIT_RD when an edit becomes pending; the updater loses its grant that cycle.
  - EDIT_RD -> EDIT_WAIT; EDIT_WAIT -> EDIT_WR after the counter expires.
  - EDIT_WR -> UPD.
  - Any state -> RENDER when render_done_in = 0. This is evaluated combinationally in the same cycle: grants and writes are suppressed in the cycle render_done_in is low.
- Aborted edit:
  - An edit interrupted before its write stays pending and restarts from EDIT_RD in the next blank.
  - No partial write ever occurs.
- Updater reads:
  - Each granted read pushes a 1 into a RD_LATENCY-deep tag shift register.
  - upd_rvalid_out = tag output; upd_data_out = mem_dout_in when upd_rvalid_out = 1.
  - Reads granted before a switch to RENDER still return upd_rvalid_out exactly RD_LATENCY cycles later.
- Writes: granted writes complete in the grant cycle; no acknowledge beyond upd_gnt_out.
- Renderer path:
  - Zero added latency. render_data_out = mem_dout_in at all times.
  - The renderer sees arbitrary data while render_done_in = 1.
- Simultaneous events: if upd_req_in and edit_req_in arrive in the same UPD cycle, the updater is granted that cycle and the edit starts on the next cycle.

Test Plan:
- Reset mid-EDIT_WAIT -> state_out = 0, edit_busy_out = 0, mem_we_out = 0 immediately, with no clock edge.
- render_done_in = 0, render_addr_in = 0x123, upd_req_in = 1 -> mem_addr_out = 0x123, upd_gnt_out = 0, mem_we_out = 0.
- Blank; updater reads addr 0x010, then 0x011 on consecutive cycles, with mem returning 0xAAAA, 0x5555 -> upd_rvalid_out high 2 cycles later, upd_data_out = 0xAAAA then 0x5555.
- edit_req_in during RENDER with addr 0x020, mask 0x8000, word holding 0x0F0F; then blank -> EDIT_RD, EDIT_WAIT, EDIT_WR writes 0x8F0F; busy clears; state returns to UPD.
- Edit starts and render_done_in drops during EDIT_WAIT -> no write, busy stays 1; the next blank redoes the full RMW and writes once.
- Second edit_req_in while busy -> ignored; only the first mask is applied.
